// File: rtl/led_scan_decoder.sv
// led_scan_decoder: registered one-hot LED driver with decode, scan up/down/bounce, prescaler and position load
module led_scan_decoder #(
    parameter int SEL_W      = 3,
    parameter int DIV_W      = 4,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            enable,
    input  logic [SEL_W-1:0]      switch,
    input  logic [1:0]            mode,
    input  logic [DIV_W-1:0]      div,
    input  logic                  load,
    output logic [(1<<SEL_W)-1:0] led,
    output logic [SEL_W-1:0]      pos,
    output logic                  wrap
);
    localparam int N = 1 << SEL_W;
    localparam logic [SEL_W-1:0] MAX = SEL_W'(N - 1);
    localparam logic [N-1:0] DARK = {N{ACTIVE_LOW}};

    logic [DIV_W-1:0] cnt, cnt_n;
    logic [SEL_W-1:0] pos_n;
    logic             dir, dir_n, wrap_n, en;
    logic [N-1:0]     led_n;

    assign en = enable == 3'b100;

    always_comb begin
        pos_n  = pos;
        cnt_n  = cnt;
        dir_n  = dir;
        wrap_n = 1'b0;
        if (!en) begin
            pos_n = pos;
        end else if (load) begin
            pos_n = switch;
            cnt_n = '0;
            dir_n = 1'b0;
        end else if (mode == 2'b00) begin
            pos_n = switch;
            cnt_n = '0;
        end else if (cnt != div) begin
            cnt_n = cnt + 1'b1;
        end else begin
            cnt_n = '0;
            case (mode)
                2'b01: begin
                    pos_n  = pos + 1'b1;
                    wrap_n = pos == MAX;
                end
                2'b10: begin
                    pos_n  = pos - 1'b1;
                    wrap_n = pos == '0;
                end
                default: begin
                    // bounce reverses at either end instead of wrapping
                    wrap_n = dir ? pos == '0 : pos == MAX;
                    dir_n  = wrap_n ? ~dir : dir;
                    pos_n  = (dir ^ wrap_n) ? pos - 1'b1 : pos + 1'b1;
                end
            endcase
        end
        led_n = en ? DARK ^ (N'(1) << pos_n) : DARK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led  <= DARK;
            pos  <= '0;
            cnt  <= '0;
            dir  <= 1'b0;
            wrap <= 1'b0;
        end else begin
            led  <= led_n;
            pos  <= pos_n;
            cnt  <= cnt_n;
            dir  <= dir_n;
            wrap <= wrap_n;
        end
    end
endmodule

// File: tb/tb_led_scan_decoder.sv
// tb_led_scan_decoder: directed literal checks plus randomized run against an arithmetic reference model
module tb_led_scan_decoder;
    localparam int N = 8;

    logic       clk = 0, rst = 0, load = 0;
    logic [2:0] enable = 0, switch = 0;
    logic [1:0] mode = 0;
    logic [3:0] div = 0;
    logic [7:0] led;
    logic [2:0] pos;
    logic       wrap;

    int passes = 0, total = 0;
    int m_pos = 0, m_cnt = 0, m_dir = 0, m_wrap = 0, m_en = 0;

    always #5 clk = ~clk;

    led_scan_decoder #(.SEL_W(3), .DIV_W(4), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .switch(switch), .mode(mode),
        .div(div), .load(load), .led(led), .pos(pos), .wrap(wrap)
    );

    function automatic logic [7:0] m_led();
        logic [7:0] r;
        for (int i = 0; i < N; i++) r[i] = !(m_en != 0 && i == m_pos);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model();
        m_wrap = 0;
        if (rst) begin
            m_pos = 0; m_cnt = 0; m_dir = 0; m_en = 0;
        end else if (enable != 3'b100) begin
            m_en = 0;
        end else begin
            m_en = 1;
            if (load) begin
                m_pos = switch; m_cnt = 0; m_dir = 0;
            end else if (mode == 0) begin
                m_pos = switch; m_cnt = 0;
            end else if (m_cnt != div) begin
                m_cnt = (m_cnt + 1) % 16;
            end else begin
                m_cnt = 0;
                if (mode == 1) begin
                    m_wrap = m_pos == N - 1;
                    m_pos = (m_pos + 1) % N;
                end else if (mode == 2) begin
                    m_wrap = m_pos == 0;
                    m_pos = (m_pos + N - 1) % N;
                end else if (m_dir == 0 && m_pos == N - 1) begin
                    m_pos = N - 2; m_dir = 1; m_wrap = 1;
                end else if (m_dir == 1 && m_pos == 0) begin
                    m_pos = 1; m_dir = 0; m_wrap = 1;
                end else begin
                    m_pos = m_dir ? m_pos - 1 : m_pos + 1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [2:0] e, input logic [2:0] s,
                        input logic [1:0] m, input logic [3:0] d, input logic l);
        rst = r; enable = e; switch = s; mode = m; div = d; load = l;
        @(posedge clk);
        model();
        #1;
        chk("led", led, m_led());
        chk("pos", pos, m_pos);
        chk("wrap", wrap, m_wrap);
    endtask

    initial begin
        logic [7:0] dec_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        int up_seq [5] = '{6, 6, 7, 7, 0};
        int bn_seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 1};
        int bn_wr  [9] = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
        #2;
        step(1, 3'b100, 0, 0, 0, 0);
        step(1, 3'b100, 0, 0, 0, 0);
        chk("reset_led", led, 8'hFF);
        chk("reset_pos", pos, 0);
        chk("reset_wrap", wrap, 0);
        for (int s = 0; s < 8; s++) begin
            step(0, 3'b100, 3'(s), 0, 0, 0);
            chk("decode_led", led, dec_tab[s]);
            chk("decode_pos", pos, s);
        end
        step(0, 3'b100, 6, 1, 1, 1);
        chk("up_pos", pos, up_seq[0]);
        for (int i = 1; i < 5; i++) begin
            step(0, 3'b100, 0, 1, 1, 0);
            chk("up_pos", pos, up_seq[i]);
            chk("up_wrap", wrap, i == 4);
        end
        step(0, 3'b100, 0, 1, 2, 1);
        step(0, 3'b100, 0, 1, 2, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, i == 1 ? 3'b000 : 3'b101, 5, 3, 0, 1);
            chk("gate_led", led, 8'hFF);
            chk("gate_pos", pos, 0);
        end
        step(0, 3'b100, 0, 1, 2, 0);
        chk("resume_hold", pos, 0);
        step(0, 3'b100, 0, 1, 2, 0);
        chk("resume_step", pos, 1);
        step(0, 3'b100, 6, 3, 0, 1);
        for (int i = 0; i < 9; i++) begin
            step(0, 3'b100, 0, 3, 0, 0);
            chk("bounce_pos", pos, bn_seq[i]);
            chk("bounce_wrap", wrap, bn_wr[i]);
        end
        step(0, 3'b100, 0, 2, 1, 0);
        step(0, 3'b100, 0, 2, 1, 0);
        step(0, 3'b100, 3, 2, 1, 1);
        chk("load_pos", pos, 3);
        step(0, 3'b100, 0, 2, 1, 0);
        chk("load_hold", pos, 3);
        step(0, 3'b100, 0, 2, 1, 0);
        chk("load_step", pos, 2);
        step(1, 3'b100, 5, 1, 0, 1);
        chk("rst_load_pos", pos, 0);
        chk("rst_load_led", led, 8'hFF);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 5) == 0 ? 3'($urandom) : 3'b100,
                 3'($urandom),
                 $urandom_range(0, 7) == 0 ? 2'b00 : 2'($urandom),
                 $urandom_range(0, 7) == 0 ? 4'($urandom) : 4'($urandom_range(0, 2)),
                 $urandom_range(0, 11) == 0);
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
